pong_match_controller: RTL and testbench
========================================

PONG_MATCH_CONTROLLER -- requirements
Module: pong_match_controller

Interface
REQ-001 SHALL have parameter CLOCK_GAME_PERIOD, default 400_000, clk cycles per game tick.
REQ-002 SHALL have parameter SCORE_WIN_THRESHOLD, default 5, points needed to win; legal range 1..7.
REQ-003 SHALL have parameter SERVE_DELAY_TICKS, default 64, game ticks spent in SERVE before play.
REQ-004 SHALL have parameter GAME_OVER_TICKS, default 256, game ticks spent in GAME_OVER before IDLE.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port resetSwitch  input  1  synchronous, active-high reset.
REQ-007 SHALL have port startButton  input  1  level input; its rising edge starts a match.
REQ-008 SHALL have port pointP1  input  1  one-cycle pulse: ball crossed the right boundary, player 1 scores.
REQ-009 SHALL have port pointP2  input  1  one-cycle pulse: ball crossed the left boundary, player 2 scores.
REQ-010 SHALL have port gameTick  output  1  one-cycle strobe every CLOCK_GAME_PERIOD cycles.
REQ-011 SHALL have port ballLoad  output  1  one-cycle pulse: reload ball start position.
REQ-012 SHALL have port serveDir  output  1  serve direction: 1 = toward right, 0 = toward left.
REQ-013 SHALL have port ballRun  output  1  enables ball and paddle updates.
REQ-014 SHALL have ports player1Score and player2Score  output  3 each  current scores.
REQ-015 SHALL have port winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-016 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-017 Tick counter SHALL run 0..CLOCK_GAME_PERIOD-1 and wrap; it is free-running in every state; gameTick=1 exactly in the cycle the count equals CLOCK_GAME_PERIOD-1.
REQ-018 FSM states SHALL be IDLE, SERVE, PLAY, POINT, GAME_OVER; all outputs are registered.
REQ-019 IDLE: ballRun=0, scores=0, winner=00; a startButton rising edge (registered edge detect) SHALL go to SERVE with serveDir=1.
REQ-020 Every entry into SERVE SHALL assert ballLoad for exactly that first SERVE cycle; ballLoad is 0 at all other times.
REQ-021 Tick-delay counter SHALL clear on every state entry and increment on gameTick; SERVE SHALL go to PLAY in the cycle after the SERVE_DELAY_TICKS-th tick.
REQ-022 ballRun SHALL be 1 only in PLAY.
REQ-023 In PLAY, pointP1 SHALL increment player1Score, set serveDir=0 and go to POINT; pointP2 SHALL increment player2Score, set serveDir=1 and go to POINT.
REQ-024 If pointP1 and pointP2 are both high in one cycle, pointP1 SHALL win and pointP2 SHALL be dropped.
REQ-025 pointP1 and pointP2 SHALL be ignored outside PLAY.
REQ-026 POINT SHALL last one cycle: if a score equals SCORE_WIN_THRESHOLD, go to GAME_OVER and set winner; otherwise go to SERVE.
REQ-027 Latency: a point pulse in cycle N SHALL make the score visible in N+1 (state POINT) and place the FSM in SERVE or GAME_OVER in N+2 (ballLoad=1 in N+2 when the next state is SERVE).
REQ-028 Scores SHALL saturate at SCORE_WIN_THRESHOLD and never wrap.
REQ-029 GAME_OVER: scores and winner held; ballRun=0; after GAME_OVER_TICKS ticks, go to IDLE, clearing scores and winner in the same edge.
REQ-030 startButton SHALL be ignored outside IDLE.

Reset
REQ-031 resetSwitch high at any clk edge, including mid-match or mid-delay, SHALL force: state=IDLE, both counters=0, scores=0, winner=00, serveDir=1, ballLoad=0, ballRun=0, gameTick=0, edge-detect register=0.
REQ-032 A startButton held high through reset release SHALL NOT start a match; a new rising edge is required.

Structure
REQ-033 Shared package pong_pkg SHALL hold the state encoding, winner codes, and defaults for CLOCK_GAME_PERIOD and SCORE_WIN_THRESHOLD.
REQ-034 Tick generation SHALL be a sub-module pong_tick_gen (clk, resetSwitch, gameTick); no derived clocks anywhere.

Verification (CLOCK_GAME_PERIOD=4, SERVE_DELAY_TICKS=2, GAME_OVER_TICKS=3, SCORE_WIN_THRESHOLD=2)
REQ-035 Reset, then idle 20 cycles -> gameTick high every 4th cycle, state=IDLE, ballRun=0.
REQ-036 startButton rise -> SERVE with ballLoad=1 for one cycle and serveDir=1; PLAY after 2 ticks; ballRun=1.
REQ-037 pointP2 in PLAY at cycle N -> player2Score=1 at N+1, SERVE with ballLoad=1 and serveDir=1 at N+2.
REQ-038 Simultaneous pointP1 and pointP2 -> only player1Score increments, serveDir=0.
REQ-039 Two pointP1 points -> GAME_OVER, winner=01, scores hold at 2/0; IDLE after 3 ticks with scores=0 and winner=00.
REQ-040 resetSwitch during SERVE with startButton held -> IDLE with all outputs at reset values; no restart until startButton falls and rises again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state and winner codes,
// parameter defaults and the saturating score helper.
package pong_pkg;

  localparam int DEFAULT_CLOCK_GAME_PERIOD   = 400_000;
  localparam int DEFAULT_SCORE_WIN_THRESHOLD = 5;
  localparam int DEFAULT_SERVE_DELAY_TICKS   = 64;
  localparam int DEFAULT_GAME_OVER_TICKS     = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  // Scores stop at the winning threshold instead of wrapping.
  function automatic logic [2:0] sat_inc(input logic [2:0] score, input logic [2:0] limit);
    if (score >= limit) begin
      return score;
    end else begin
      return score + 3'd1;
    end
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running game tick generator: one-cycle strobe every CLOCK_GAME_PERIOD
// cycles, registered so it is high exactly while the count sits at its last value.
module pong_tick_gen #(
  parameter int CLOCK_GAME_PERIOD = pong_pkg::DEFAULT_CLOCK_GAME_PERIOD
) (
  input  logic clk,
  input  logic resetSwitch,
  output logic gameTick
);

  localparam int CW = (CLOCK_GAME_PERIOD > 1) ? $clog2(CLOCK_GAME_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_GAME_PERIOD - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next;

  // Next count value with wrap at the end of the period.
  always_comb begin
    if (count_r == LAST) begin
      count_next = {CW{1'b0}};
    end else begin
      count_next = count_r + 1'b1;
    end
  end

  // Count register and strobe aligned with the last count value.
  always_ff @(posedge clk) begin
    if (resetSwitch) begin
      count_r  <= {CW{1'b0}};
      gameTick <= 1'b0;
    end else begin
      count_r  <= count_next;
      gameTick <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencing: serve delay, play, point scoring and game-over hold,
// with every output registered.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int CLOCK_GAME_PERIOD   = DEFAULT_CLOCK_GAME_PERIOD,
  parameter int SCORE_WIN_THRESHOLD = DEFAULT_SCORE_WIN_THRESHOLD,
  parameter int SERVE_DELAY_TICKS   = DEFAULT_SERVE_DELAY_TICKS,
  parameter int GAME_OVER_TICKS     = DEFAULT_GAME_OVER_TICKS
) (
  input  logic       clk,
  input  logic       resetSwitch,
  input  logic       startButton,
  input  logic       pointP1,
  input  logic       pointP2,
  output logic       gameTick,
  output logic       ballLoad,
  output logic       serveDir,
  output logic       ballRun,
  output logic [2:0] player1Score,
  output logic [2:0] player2Score,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int DLY_MAX = (SERVE_DELAY_TICKS > GAME_OVER_TICKS) ? SERVE_DELAY_TICKS : GAME_OVER_TICKS;
  localparam int DW = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
  localparam logic [2:0]    WIN_SCORE  = 3'(SCORE_WIN_THRESHOLD);
  localparam logic [DW-1:0] SERVE_LAST = DW'(SERVE_DELAY_TICKS - 1);
  localparam logic [DW-1:0] OVER_LAST  = DW'(GAME_OVER_TICKS - 1);

  state_t        state_r;
  winner_t       winner_r;
  logic [DW-1:0] dly_r;
  logic          start_low_r;
  logic          start_rise;

  pong_tick_gen #(
    .CLOCK_GAME_PERIOD(CLOCK_GAME_PERIOD)
  ) u_tick_gen (
    .clk        (clk),
    .resetSwitch(resetSwitch),
    .gameTick   (gameTick)
  );

  // start_low_r resets to 0, so a button held through reset must be seen low first.
  assign start_rise = startButton & start_low_r;
  assign state      = state_r;
  assign winner     = winner_r;

  // Match state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (resetSwitch) begin
      state_r      <= ST_IDLE;
      winner_r     <= WIN_NONE;
      dly_r        <= {DW{1'b0}};
      start_low_r  <= 1'b0;
      player1Score <= 3'd0;
      player2Score <= 3'd0;
      serveDir     <= 1'b1;
      ballLoad     <= 1'b0;
      ballRun      <= 1'b0;
    end else begin
      start_low_r <= ~startButton;
      ballLoad    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ballRun <= 1'b0;
          if (start_rise) begin
            state_r  <= ST_SERVE;
            serveDir <= 1'b1;
            ballLoad <= 1'b1;
            dly_r    <= {DW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (gameTick) begin
            if (dly_r == SERVE_LAST) begin
              state_r <= ST_PLAY;
              ballRun <= 1'b1;
              dly_r   <= {DW{1'b0}};
            end else begin
              dly_r <= dly_r + 1'b1;
            end
          end else begin
            dly_r <= dly_r;
          end
        end
        ST_PLAY: begin
          // pointP1 takes priority when both pulses arrive together.
          if (pointP1) begin
            player1Score <= sat_inc(player1Score, WIN_SCORE);
            serveDir     <= 1'b0;
            ballRun      <= 1'b0;
            state_r      <= ST_POINT;
            dly_r        <= {DW{1'b0}};
          end else if (pointP2) begin
            player2Score <= sat_inc(player2Score, WIN_SCORE);
            serveDir     <= 1'b1;
            ballRun      <= 1'b0;
            state_r      <= ST_POINT;
            dly_r        <= {DW{1'b0}};
          end else begin
            ballRun <= 1'b1;
          end
        end
        ST_POINT: begin
          dly_r <= {DW{1'b0}};
          if (player1Score == WIN_SCORE) begin
            winner_r <= WIN_P1;
            state_r  <= ST_GAME_OVER;
          end else if (player2Score == WIN_SCORE) begin
            winner_r <= WIN_P2;
            state_r  <= ST_GAME_OVER;
          end else begin
            state_r  <= ST_SERVE;
            ballLoad <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          ballRun <= 1'b0;
          if (gameTick) begin
            if (dly_r == OVER_LAST) begin
              state_r      <= ST_IDLE;
              player1Score <= 3'd0;
              player2Score <= 3'd0;
              winner_r     <= WIN_NONE;
              dly_r        <= {DW{1'b0}};
            end else begin
              dly_r <= dly_r + 1'b1;
            end
          end else begin
            dly_r <= dly_r;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          winner_r     <= WIN_NONE;
          dly_r        <= {DW{1'b0}};
          player1Score <= 3'd0;
          player2Score <= 3'd0;
          serveDir     <= 1'b1;
          ballRun      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench: a cycle-level behavioural model of the match rules is
// compared against every output after each clock edge, plus directed literal checks.
module tb_pong_match_controller;

  localparam int P     = 4;
  localparam int SV    = 2;
  localparam int GO    = 3;
  localparam int WIN   = 2;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic       clk;
  logic       resetSwitch, startButton, pointP1, pointP2;
  logic       gameTick, ballLoad, serveDir, ballRun;
  logic [2:0] player1Score, player2Score, state;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  // Model of the match as seen after the most recent clock edge.
  int m_k = 0, m_state = S_IDLE, m_p1 = 0, m_p2 = 0, m_win = 0, m_ticks = 0;
  bit m_tick = 1'b0, m_dir = 1'b1, m_load = 1'b0, m_btn_low = 1'b0;

  pong_match_controller #(
    .CLOCK_GAME_PERIOD  (P),
    .SCORE_WIN_THRESHOLD(WIN),
    .SERVE_DELAY_TICKS  (SV),
    .GAME_OVER_TICKS    (GO)
  ) dut (
    .clk         (clk),
    .resetSwitch (resetSwitch),
    .startButton (startButton),
    .pointP1     (pointP1),
    .pointP2     (pointP2),
    .gameTick    (gameTick),
    .ballLoad    (ballLoad),
    .serveDir    (serveDir),
    .ballRun     (ballRun),
    .player1Score(player1Score),
    .player2Score(player2Score),
    .winner      (winner),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the rule model across one clock edge using the inputs the DUT sees.
  task automatic model_step();
    bit tick_before = m_tick;
    bit rise = startButton && m_btn_low;
    if (resetSwitch) begin
      m_k = 0; m_tick = 1'b0; m_state = S_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0;
      m_dir = 1'b1; m_load = 1'b0; m_ticks = 0; m_btn_low = 1'b0;
    end else begin
      m_k++;
      m_tick = ((m_k % P) == P - 1);
      m_btn_low = !startButton;
      m_load = 1'b0;
      case (m_state)
        S_IDLE: if (rise) begin m_state = S_SERVE; m_dir = 1'b1; m_load = 1'b1; m_ticks = 0; end
        S_SERVE: if (tick_before) begin
          m_ticks++;
          if (m_ticks == SV) begin m_state = S_PLAY; m_ticks = 0; end
        end
        S_PLAY: begin
          if (pointP1) begin m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1; m_dir = 1'b0; m_state = S_POINT; end
          else if (pointP2) begin m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1; m_dir = 1'b1; m_state = S_POINT; end
        end
        S_POINT: begin
          m_ticks = 0;
          if (m_p1 == WIN) begin m_win = 1; m_state = S_OVER; end
          else if (m_p2 == WIN) begin m_win = 2; m_state = S_OVER; end
          else begin m_state = S_SERVE; m_load = 1'b1; end
        end
        S_OVER: if (tick_before) begin
          m_ticks++;
          if (m_ticks == GO) begin m_state = S_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_ticks = 0; end
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  task automatic compare_model();
    chk("gameTick", gameTick, m_tick);
    chk("state", state, m_state);
    chk("ballLoad", ballLoad, m_load);
    chk("ballRun", ballRun, (m_state == S_PLAY) ? 1 : 0);
    chk("serveDir", serveDir, m_dir);
    chk("player1Score", player1Score, m_p1);
    chk("player2Score", player2Score, m_p2);
    chk("winner", winner, m_win);
  endtask

  // One clock: model steps at the edge, outputs are checked 1 time unit later.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_model();
    end
  endtask

  task automatic wait_state(input int s, input string name);
    for (int i = 0; i < 40; i++) begin
      if (state == 3'(s)) break;
      cyc(1);
    end
    chk(name, state, s);
  endtask

  task automatic pulse(input bit p1, input bit p2);
    pointP1 = p1; pointP2 = p2;
    cyc(1);
    pointP1 = 1'b0; pointP2 = 1'b0;
  endtask

  initial begin
    int tick_count;
    resetSwitch = 1'b1; startButton = 1'b0; pointP1 = 1'b0; pointP2 = 1'b0;
    #1;
    cyc(3);
    chk("rst_state", state, 0);
    chk("rst_serveDir", serveDir, 1);
    chk("rst_gameTick", gameTick, 0);
    chk("rst_winner", winner, 0);
    resetSwitch = 1'b0;

    // Idle for 20 cycles: ticks on every 4th cycle.
    tick_count = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      tick_count += int'(gameTick);
      chk("idle_state", state, 0);
      chk("idle_ballRun", ballRun, 0);
    end
    chk("idle_tick_count", tick_count, 5);

    // First match: serve, point to P2, simultaneous points, then P1 wins.
    startButton = 1'b1;
    cyc(1);
    chk("start_serve", state, 1);
    chk("start_ballLoad", ballLoad, 1);
    chk("start_serveDir", serveDir, 1);
    cyc(1);
    chk("ballLoad_one_cycle", ballLoad, 0);
    startButton = 1'b0;
    pulse(1'b1, 1'b0);
    chk("point_ignored_in_serve", player1Score, 0);
    wait_state(S_PLAY, "reach_play_1");
    chk("play_ballRun", ballRun, 1);
    startButton = 1'b1;
    cyc(2);
    chk("start_ignored_in_play", state, 2);
    startButton = 1'b0;

    pulse(1'b0, 1'b1);
    chk("p2_score_n1", player2Score, 1);
    chk("p2_point_state", state, 3);
    cyc(1);
    chk("p2_serve_n2", state, 1);
    chk("p2_ballLoad_n2", ballLoad, 1);
    chk("p2_serveDir", serveDir, 1);

    wait_state(S_PLAY, "reach_play_2");
    pulse(1'b1, 1'b1);
    chk("both_p1_score", player1Score, 1);
    chk("both_p2_held", player2Score, 1);
    chk("both_serveDir", serveDir, 0);

    wait_state(S_PLAY, "reach_play_3");
    pulse(1'b1, 1'b0);
    cyc(1);
    chk("m1_game_over", state, 4);
    chk("m1_winner", winner, 1);
    wait_state(S_IDLE, "m1_back_idle");
    chk("m1_idle_p1", player1Score, 0);

    // Second match: two P1 points, saturation and hold in GAME_OVER.
    startButton = 1'b1;
    cyc(1);
    startButton = 1'b0;
    wait_state(S_PLAY, "reach_play_4");
    pulse(1'b1, 1'b0);
    wait_state(S_PLAY, "reach_play_5");
    pulse(1'b1, 1'b0);
    cyc(1);
    chk("m2_game_over", state, 4);
    chk("m2_winner", winner, 1);
    chk("m2_p1", player1Score, 2);
    chk("m2_p2", player2Score, 0);
    pulse(1'b1, 1'b0);
    chk("m2_p1_saturated", player1Score, 2);
    wait_state(S_IDLE, "m2_back_idle");
    chk("m2_idle_p1", player1Score, 0);
    chk("m2_idle_winner", winner, 0);

    // Reset during SERVE with the button held.
    startButton = 1'b1;
    cyc(1);
    chk("m3_serve", state, 1);
    resetSwitch = 1'b1;
    cyc(2);
    chk("m3_reset_state", state, 0);
    chk("m3_reset_ballLoad", ballLoad, 0);
    resetSwitch = 1'b0;
    cyc(6);
    chk("m3_held_no_start", state, 0);
    startButton = 1'b0;
    cyc(1);
    startButton = 1'b1;
    cyc(1);
    chk("m3_restart", state, 1);
    startButton = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
